// File: rtl/bus_burst_sram_slave.sv
// ---------------------------------------------------------------------------
// bus_burst_sram_slave
//
// Burst memory target on the shared system bus. It decodes begin cycles that
// fall inside its address window, stores write bursts into an internal SRAM
// with per-byte enables, and answers read bursts with one word per cycle
// followed by a one-cycle end-of-transaction pulse. A periodic out_busy
// pulse during writes gives bus masters a back-pressuring target.
//
// Parameters
//   baseAddress  byte base of the window (aligned to nrOfEntries*4)
//   nrOfEntries  number of 32-bit words (power of two)
//   busyPeriod   out_busy pulses once after every busyPeriod accepted words
//                during a write; 0 disables it
//
// Ports
//   clock                 system clock, rising edge
//   reset                 asynchronous active-low reset
//   in_beginTransaction   master starts a transaction this cycle
//   in_endTransaction     master ends / aborts the transaction
//   in_readNotWrite       direction, valid with begin (1 = read)
//   in_burstSize[7:0]     words in burst minus one, valid with begin
//   in_addressData[31:0]  byte address on begin, write data afterwards
//   in_byteEnables[3:0]   per-byte write enables for each write word
//   in_dataValid          write word present
//   in_busy               master cannot take read data this cycle
//   out_addressData[31:0] read data, 0 when out_dataValid is 0
//   out_dataValid         read word present
//   out_endTransaction    one-cycle pulse after the last read word
//   out_busy              slave cannot take a write word this cycle
//   out_error             one-cycle pulse: transaction rejected
// ---------------------------------------------------------------------------
module bus_burst_sram_slave #(
    parameter logic [31:0] baseAddress = 32'h5000_0000,
    parameter int          nrOfEntries = 512,
    parameter int          busyPeriod  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_beginTransaction,
    input  logic        in_endTransaction,
    input  logic        in_readNotWrite,
    input  logic [7:0]  in_burstSize,
    input  logic [31:0] in_addressData,
    input  logic [3:0]  in_byteEnables,
    input  logic        in_dataValid,
    input  logic        in_busy,
    output logic [31:0] out_addressData,
    output logic        out_dataValid,
    output logic        out_endTransaction,
    output logic        out_busy,
    output logic        out_error
);

    localparam int          W          = $clog2(nrOfEntries);
    localparam logic [31:0] LAST_ENTRY = 32'(nrOfEntries - 1);
    localparam logic [15:0] BUSY_LAST  = (busyPeriod > 0) ? 16'(busyPeriod - 1) : 16'd0;

    typedef enum logic [1:0] {IDLE, WRITE, READ, ERROR} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  idx_q, idx_d;            // next word to write / next word to fetch
    logic [8:0]    words_left_q, words_left_d;
    logic [8:0]    fetch_left_q, fetch_left_d;
    logic          ram_valid_q, ram_valid_d; // RAM output register holds an unconsumed word
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_end_q, out_end_d;
    logic          out_busy_q, out_busy_d;
    logic [15:0]   busy_cnt_q, busy_cnt_d;

    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  rd_addr;
    logic [31:0]   ram_rdata;

    logic [W-1:0]  begin_idx;
    logic          sel_hit;
    logic          reject;
    logic          consume;
    logic          move;

    assign begin_idx = in_addressData[W+1:2];
    assign sel_hit   = (in_addressData[31:W+2] == baseAddress[31:W+2]);
    // Bursts must fit inside the array; they never wrap to index 0.
    assign reject    = (in_addressData[1:0] != 2'b00) ||
                       ((32'(begin_idx) + 32'(in_burstSize)) > LAST_ENTRY);

    // Two-stage read pipe: RAM output register feeding the output hold
    // register. A word moves forward whenever the output slot is empty or is
    // being consumed, so in_busy never drops or repeats a word.
    assign consume = out_valid_q & ~in_busy;
    assign move    = ram_valid_q & (~out_valid_q | consume);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        words_left_d = words_left_q;
        fetch_left_d = fetch_left_q;
        ram_valid_d  = 1'b0;
        out_valid_d  = 1'b0;
        out_data_d   = '0;
        out_end_d    = 1'b0;
        out_busy_d   = 1'b0;
        busy_cnt_d   = busy_cnt_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = idx_q;

        unique case (state_q)
            IDLE: begin
                if (in_beginTransaction && sel_hit) begin
                    words_left_d = {1'b0, in_burstSize} + 9'd1;
                    busy_cnt_d   = '0;
                    if (reject) begin
                        state_d = ERROR;
                    end else if (in_readNotWrite) begin
                        // First fetch is issued on the begin cycle so the
                        // first word reaches the output two cycles later.
                        state_d      = READ;
                        rd_en        = 1'b1;
                        rd_addr      = begin_idx;
                        ram_valid_d  = 1'b1;
                        fetch_left_d = {1'b0, in_burstSize};
                        idx_d        = begin_idx + W'(1);
                    end else begin
                        state_d = WRITE;
                        idx_d   = begin_idx;
                    end
                end
            end

            WRITE: begin
                if (in_endTransaction) begin
                    state_d = IDLE;
                end else if (in_dataValid) begin
                    if (words_left_q == 9'd0) begin
                        state_d = ERROR;
                    end else if (!out_busy_q) begin
                        wr_en        = 1'b1;
                        idx_d        = idx_q + W'(1);
                        words_left_d = words_left_q - 9'd1;
                        if (busyPeriod > 0) begin
                            if (busy_cnt_q == BUSY_LAST) begin
                                out_busy_d = 1'b1;
                                busy_cnt_d = '0;
                            end else begin
                                busy_cnt_d = busy_cnt_q + 16'd1;
                            end
                        end
                    end
                end
            end

            READ: begin
                if (in_endTransaction) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = out_valid_q;
                    out_data_d  = out_data_q;
                    ram_valid_d = ram_valid_q;
                    if (consume) begin
                        out_valid_d  = 1'b0;
                        out_data_d   = '0;
                        words_left_d = words_left_q - 9'd1;
                    end
                    if (move) begin
                        out_valid_d = 1'b1;
                        out_data_d  = ram_rdata;
                        ram_valid_d = 1'b0;
                    end
                    if ((fetch_left_q != 9'd0) && (!ram_valid_q || move)) begin
                        rd_en        = 1'b1;
                        rd_addr      = idx_q;
                        ram_valid_d  = 1'b1;
                        idx_d        = idx_q + W'(1);
                        fetch_left_d = fetch_left_q - 9'd1;
                    end
                    if (consume && (words_left_q == 9'd1)) begin
                        out_end_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            ERROR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            words_left_q <= '0;
            fetch_left_q <= '0;
            ram_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_end_q    <= 1'b0;
            out_busy_q   <= 1'b0;
            busy_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            words_left_q <= words_left_d;
            fetch_left_q <= fetch_left_d;
            ram_valid_q  <= ram_valid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_end_q    <= out_end_d;
            out_busy_q   <= out_busy_d;
            busy_cnt_q   <= busy_cnt_d;
        end
    end

    // One byte-wide RAM per lane: byte enables become plain lane write
    // enables and contents survive reset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [nrOfEntries];
            logic [7:0] lane_rdata_q;

            always_ff @(posedge clock) begin
                if (wr_en && in_byteEnables[gi]) begin
                    lane_mem[idx_q] <= in_addressData[gi*8 +: 8];
                end
                if (rd_en) begin
                    lane_rdata_q <= lane_mem[rd_addr];
                end
            end

            assign ram_rdata[gi*8 +: 8] = lane_rdata_q;
        end
    endgenerate

    assign out_addressData    = out_data_q;
    assign out_dataValid      = out_valid_q;
    assign out_endTransaction = out_end_q;
    assign out_busy           = out_busy_q;
    assign out_error          = (state_q == ERROR);

endmodule

// File: tb/tb_bus_burst_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_bus_burst_sram_slave
//
// Two instances share clock and reset: dut0 never signals busy, dut1 pulses
// out_busy after every 2 accepted write words. Each has its own bus inputs.
// Stimulus tasks advance one cycle at a time and, from the transaction rules
// (error one cycle after begin, write words from the cycle after begin,
// read words from two cycles after begin held while in_busy, end pulse after
// the last word), set the outputs each instance must show in that cycle.
// A word-array model per instance supplies expected read data. A negedge
// process compares every cycle and prints one line per mismatch.
// ---------------------------------------------------------------------------
module tb_bus_burst_sram_slave;

    localparam logic [31:0] BASE = 32'h5000_0000;

    typedef struct packed {
        logic        dv;
        logic        en;
        logic        bsy;
        logic        err;
        logic [31:0] data;
    } outv_t;

    logic        clock;
    logic        reset;
    logic [1:0]  beg, endt, rnw, dv, bsy_in;
    logic [7:0]  bsz [2];
    logic [31:0] ad  [2];
    logic [3:0]  be  [2];
    logic [31:0] o_ad [2];
    logic [1:0]  o_dv, o_end, o_busy, o_err;

    outv_t       exp_v [2];
    logic [31:0] mdl [2][512];
    logic [31:0] got_q [$];
    int          cap_dut = -1;
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    bus_burst_sram_slave #(.baseAddress(BASE), .nrOfEntries(512), .busyPeriod(0)) dut0 (
        .clock(clock), .reset(reset),
        .in_beginTransaction(beg[0]), .in_endTransaction(endt[0]),
        .in_readNotWrite(rnw[0]), .in_burstSize(bsz[0]),
        .in_addressData(ad[0]), .in_byteEnables(be[0]),
        .in_dataValid(dv[0]), .in_busy(bsy_in[0]),
        .out_addressData(o_ad[0]), .out_dataValid(o_dv[0]),
        .out_endTransaction(o_end[0]), .out_busy(o_busy[0]), .out_error(o_err[0])
    );

    bus_burst_sram_slave #(.baseAddress(BASE), .nrOfEntries(512), .busyPeriod(2)) dut1 (
        .clock(clock), .reset(reset),
        .in_beginTransaction(beg[1]), .in_endTransaction(endt[1]),
        .in_readNotWrite(rnw[1]), .in_burstSize(bsz[1]),
        .in_addressData(ad[1]), .in_byteEnables(be[1]),
        .in_dataValid(dv[1]), .in_busy(bsy_in[1]),
        .out_addressData(o_ad[1]), .out_dataValid(o_dv[1]),
        .out_endTransaction(o_end[1]), .out_busy(o_busy[1]), .out_error(o_err[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    function automatic logic [35:0] act_of(input int d);
        return {o_dv[d], o_end[d], o_busy[d], o_err[d], o_ad[d]};
    endfunction

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h required %h", nm, cyc, act, expv);
        end
    endtask

    // Per-cycle comparison of both instances against the expected outputs.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cycle_dut%0d{dv,end,busy,err,data}", d), act_of(d), exp_v[d]);
        end
        if (cap_dut >= 0 && exp_v[cap_dut].dv && !bsy_in[cap_dut]) begin
            got_q.push_back(o_ad[cap_dut]);
        end
    end

    // Advance to the next cycle: inputs back to idle, expected outputs idle.
    task automatic tick();
        @(posedge clock);
        #1;
        beg = '0; endt = '0; rnw = '0; dv = '0; bsy_in = '0;
        for (int d = 0; d < 2; d++) begin
            bsz[d] = '0; ad[d] = '0; be[d] = '0; exp_v[d] = '0;
        end
    endtask

    task automatic chk_reset();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_outputs_dut%0d", d), act_of(d), 36'd0);
        end
    endtask

    function automatic bit sel_of(input logic [31:0] addr);
        return (addr >> 11) == (BASE >> 11);
    endfunction

    // Write burst of burst+1 words d0, d0+step, ...; optional reset while
    // word rst_word is presented, optional extra word after the burst.
    task automatic wr(input int d, input logic [31:0] addr, input int burst,
                      input logic [31:0] d0, input logic [31:0] step,
                      input logic [3:0] bem, input int rst_word, input bit extra);
        int          idx;
        int          bp;
        int          cnt;
        int          i;
        bit          busy_now;
        logic [31:0] w;
        idx = int'((addr >> 2) & 32'd511);
        bp = (d == 1) ? 2 : 0;
        cnt = 0; i = 0; busy_now = 1'b0;
        beg[d] = 1'b1; rnw[d] = 1'b0; bsz[d] = 8'(burst); ad[d] = addr;
        if (!sel_of(addr)) begin
            for (int k = 0; k <= burst; k++) begin
                tick();
                dv[d] = 1'b1; ad[d] = d0 + step * 32'(k); be[d] = bem;
            end
            tick();
            return;
        end
        if (addr[1:0] != 2'b00 || idx + burst > 511) begin
            tick();
            exp_v[d].err = 1'b1;
            tick();
            return;
        end
        tick();
        while (i <= burst) begin
            w = d0 + step * 32'(i);
            dv[d] = 1'b1; ad[d] = w; be[d] = bem;
            exp_v[d].bsy = busy_now;
            if (i == rst_word) begin
                #1 reset = 1'b0;
                exp_v[0] = '0; exp_v[1] = '0;
                #1 chk_reset();
                tick();
                reset = 1'b1;
                return;
            end
            if (!busy_now) begin
                for (int b = 0; b < 4; b++) begin
                    if (bem[b]) mdl[d][idx + i][b*8 +: 8] = w[b*8 +: 8];
                end
                i++;
                cnt++;
                busy_now = (bp > 0) && (cnt % bp == 0);
            end else begin
                busy_now = 1'b0;
            end
            tick();
        end
        if (extra) begin
            dv[d] = 1'b1; ad[d] = 32'hDEAD_BEEF; be[d] = 4'hF;
            exp_v[d].bsy = busy_now;
            tick();
            exp_v[d].err = 1'b1;
            tick();
            return;
        end
        endt[d] = 1'b1;
        exp_v[d].bsy = busy_now;
        tick();
    endtask

    // Read burst; in_busy held for busy_len cycles while word busy_word is
    // shown. abort_mode 1 = reset, 2 = in_endTransaction, at word abort_word.
    task automatic rd(input int d, input logic [31:0] addr, input int burst,
                      input int busy_word, input int busy_len,
                      input int abort_word, input int abort_mode);
        int idx;
        int w;
        int held;
        idx = int'((addr >> 2) & 32'd511);
        w = 0; held = 0;
        got_q.delete();
        beg[d] = 1'b1; rnw[d] = 1'b1; bsz[d] = 8'(burst); ad[d] = addr;
        if (!sel_of(addr)) begin
            tick(); tick(); tick();
            return;
        end
        if (addr[1:0] != 2'b00 || idx + burst > 511) begin
            tick();
            exp_v[d].err = 1'b1;
            tick();
            return;
        end
        cap_dut = d;
        tick();
        tick();
        while (w <= burst) begin
            exp_v[d].dv = 1'b1;
            exp_v[d].data = mdl[d][idx + w];
            if (w == abort_word && abort_mode == 1) begin
                #1 reset = 1'b0;
                exp_v[0] = '0; exp_v[1] = '0;
                #1 chk_reset();
                tick();
                reset = 1'b1;
                cap_dut = -1;
                return;
            end
            if (w == abort_word && abort_mode == 2) begin
                endt[d] = 1'b1;
                tick();
                tick();
                cap_dut = -1;
                return;
            end
            if (w == busy_word && held < busy_len) begin
                bsy_in[d] = 1'b1;
                held++;
            end else begin
                w++;
            end
            tick();
        end
        exp_v[d].en = 1'b1;
        tick();
        cap_dut = -1;
    endtask

    // Compare captured read words against hand-computed literal values.
    task automatic chk_q(input string nm, input logic [31:0] first,
                         input logic [31:0] step, input int n);
        chk({nm, "_count"}, 36'(got_q.size()), 36'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk($sformatf("%s_word%0d", nm, i), {4'd0, got_q[i]}, {4'd0, first + step * 32'(i)});
        end
    endtask

    initial begin
        reset = 1'b0;
        beg = '0; endt = '0; rnw = '0; dv = '0; bsy_in = '0;
        for (int d = 0; d < 2; d++) begin
            bsz[d] = '0; ad[d] = '0; be[d] = '0; exp_v[d] = '0;
        end
        tick();
        #1 chk_reset();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Four-word burst write and readback.
        wr(0, BASE + 32'h10, 3, 32'h11, 32'h11, 4'hF, -1, 1'b0);
        rd(0, BASE + 32'h10, 3, -1, 0, -1, 0);
        chk_q("plan_burst", 32'h11, 32'h11, 4);

        // Partial byte-enable overwrite.
        wr(0, BASE, 0, 32'h1122_3344, 32'h0, 4'hF, -1, 1'b0);
        wr(0, BASE, 0, 32'hAABB_CCDD, 32'h0, 4'b0011, -1, 1'b0);
        rd(0, BASE, 0, -1, 0, -1, 0);
        chk_q("byte_enable", 32'h1122_CCDD, 32'h0, 1);

        // Read with master back-pressure on the second word.
        rd(0, BASE + 32'h10, 3, 1, 2, -1, 0);
        chk_q("busy_hold", 32'h11, 32'h11, 4);

        // Last legal burst, then rejected and unselected transactions.
        wr(0, BASE + 32'd508 * 4, 3, 32'hC0DE_0000, 32'h1, 4'hF, -1, 1'b0);
        wr(0, BASE + 32'h2, 0, 32'hFFFF_FFFF, 32'h0, 4'hF, -1, 1'b0);
        wr(0, BASE + 32'd510 * 4, 3, 32'hEEEE_0000, 32'h1, 4'hF, -1, 1'b0);
        wr(0, 32'h6000_0000, 3, 32'hDDDD_0000, 32'h1, 4'hF, -1, 1'b0);
        rd(0, BASE + 32'd510 * 4, 3, -1, 0, -1, 0);
        rd(0, 32'h6000_0000, 1, -1, 0, -1, 0);
        rd(0, BASE + 32'd508 * 4, 3, -1, 0, -1, 0);
        chk_q("window_edge", 32'hC0DE_0000, 32'h1, 4);
        rd(0, BASE, 0, -1, 0, -1, 0);
        chk_q("after_reject", 32'h1122_CCDD, 32'h0, 1);

        // Periodic slave busy on the second instance.
        wr(1, BASE + 32'h100, 5, 32'hA000_0001, 32'h1, 4'hF, -1, 1'b0);
        rd(1, BASE + 32'h100, 5, -1, 0, -1, 0);
        chk_q("slave_busy", 32'hA000_0001, 32'h1, 6);

        // Word beyond the burst length is an error and is not stored.
        wr(0, BASE + 32'h40, 0, 32'h77, 32'h0, 4'hF, -1, 1'b1);
        rd(0, BASE + 32'h40, 0, -1, 0, -1, 0);
        chk_q("overrun", 32'h77, 32'h0, 1);

        // Master ends a read early: no end pulse, next read normal.
        rd(0, BASE + 32'h10, 3, -1, 0, 1, 2);
        rd(0, BASE + 32'h40, 0, -1, 0, -1, 0);
        chk_q("after_abort", 32'h77, 32'h0, 1);

        // Reset during word 3 of an 8-word write, then during a read.
        wr(0, BASE + 32'h200, 7, 32'h0BAD_0000, 32'h1, 4'hF, 2, 1'b0);
        rd(0, BASE + 32'h200, 1, -1, 0, -1, 0);
        chk_q("reset_write", 32'h0BAD_0000, 32'h1, 2);
        rd(0, BASE + 32'h10, 3, -1, 0, 2, 1);
        rd(0, BASE + 32'h10, 1, -1, 0, -1, 0);
        chk_q("reset_read", 32'h11, 32'h11, 2);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
